// File: rtl/tlb_lookup_sched.sv
// Arbitrates the single TLB lookup port between fetch, data and CP0 TLB ops,
// registers translation results and maintains the Random victim register.
module tlb_lookup_sched #(
    parameter logic [4:0] WIRED = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_vaddr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_paddr,
    output logic [2:0]  if_exc,
    input  logic        dm_req,
    input  logic [31:0] dm_vaddr,
    input  logic        dm_store,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [31:0] dm_paddr,
    output logic [2:0]  dm_exc,
    input  logic        op_req,
    input  logic [1:0]  op_code,
    input  logic [4:0]  op_index,
    input  logic [31:0] op_entryhi,
    output logic        op_busy,
    output logic        op_done,
    output logic        op_probe_miss,
    output logic [4:0]  op_probe_idx,
    output logic [4:0]  random,
    output logic [31:0] tlb_vaddr,
    output logic [1:0]  tlb_reftype,
    input  logic [31:0] tlb_paddr,
    input  logic        tlb_refill,
    input  logic        tlb_invalid,
    input  logic        tlb_modified,
    input  logic [4:0]  tlb_hitidx,
    output logic [4:0]  tlb_ridx,
    output logic        tlb_we
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        OP_WAIT,
        OP_EXEC,
        OP_DONE
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    state_t      state_q, state_d;
    logic        last_dm_q, last_dm_d;
    logic [1:0]  code_q, code_d;
    logic [4:0]  index_q, index_d;
    logic [31:0] entryhi_q, entryhi_d;
    logic [4:0]  random_q, random_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;
    logic [31:0] if_paddr_q, if_paddr_d;
    logic [31:0] dm_paddr_q, dm_paddr_d;
    logic [2:0]  if_exc_q, if_exc_d;
    logic [2:0]  dm_exc_q, dm_exc_d;
    logic        probe_miss_q, probe_miss_d;
    logic [4:0]  probe_idx_q, probe_idx_d;

    logic        can_grant;
    logic        pick_if;
    logic        exec;
    logic [31:0] sel_vaddr;
    logic [31:0] xl_paddr;
    logic [2:0]  xl_exc;

    always_comb begin
        can_grant = (state_q == IDLE || state_q == LOOKUP) && !op_req;
        pick_if   = if_req && (!dm_req || last_dm_q);
        if_gnt    = can_grant && pick_if;
        dm_gnt    = can_grant && dm_req && !pick_if;
        exec      = (state_q == OP_EXEC);
        sel_vaddr = dm_gnt ? dm_vaddr : if_vaddr;

        // kseg0/kseg1 bypass the TLB entirely
        if (sel_vaddr[31:30] == 2'b10) begin
            xl_paddr = {3'b000, sel_vaddr[28:0]};
            xl_exc   = 3'b000;
        end else begin
            xl_paddr = tlb_paddr;
            xl_exc   = {tlb_refill, tlb_invalid, tlb_modified};
        end

        tlb_vaddr   = sel_vaddr;
        tlb_reftype = dm_gnt ? (dm_store ? 2'b10 : 2'b01) : 2'b00;
        if (exec && code_q == OP_TLBP) begin
            tlb_vaddr   = entryhi_q;
            tlb_reftype = 2'b01;
        end
        tlb_ridx = (code_q == OP_TLBWR) ? random_q : index_q;
        tlb_we   = exec && code_q[1];

        op_busy       = (state_q == OP_WAIT) || exec;
        op_done       = (state_q == OP_DONE);
        op_probe_miss = probe_miss_q;
        op_probe_idx  = probe_idx_q;
        random        = random_q;
        if_valid      = if_valid_q;
        if_paddr      = if_paddr_q;
        if_exc        = if_exc_q;
        dm_valid      = dm_valid_q;
        dm_paddr      = dm_paddr_q;
        dm_exc        = dm_exc_q;
    end

    always_comb begin
        state_d      = state_q;
        last_dm_d    = last_dm_q;
        code_d       = code_q;
        index_d      = index_q;
        entryhi_d    = entryhi_q;
        probe_miss_d = probe_miss_q;
        probe_idx_d  = probe_idx_q;
        if_valid_d   = if_gnt;
        dm_valid_d   = dm_gnt;
        if_paddr_d   = if_gnt ? xl_paddr : if_paddr_q;
        if_exc_d     = if_gnt ? xl_exc : if_exc_q;
        dm_paddr_d   = dm_gnt ? xl_paddr : dm_paddr_q;
        dm_exc_d     = dm_gnt ? xl_exc : dm_exc_q;

        if (if_gnt || dm_gnt) begin
            last_dm_d = dm_gnt;
        end

        unique case (state_q)
            IDLE, LOOKUP: begin
                if (op_req) begin
                    state_d   = OP_WAIT;
                    code_d    = op_code;
                    index_d   = op_index;
                    entryhi_d = op_entryhi;
                end else if (if_gnt || dm_gnt) begin
                    state_d = LOOKUP;
                end else begin
                    state_d = IDLE;
                end
            end
            OP_WAIT: state_d = OP_EXEC;
            OP_EXEC: begin
                state_d = OP_DONE;
                if (code_q == OP_TLBP) begin
                    probe_miss_d = tlb_refill;
                    probe_idx_d  = tlb_hitidx;
                end
            end
            OP_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // victim must not move in the cycle it is being written
        if (tlb_we && code_q == OP_TLBWR) begin
            random_d = random_q;
        end else if (random_q <= WIRED) begin
            random_d = 5'd31;
        end else begin
            random_d = random_q - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_dm_q    <= 1'b1;
            code_q       <= 2'b00;
            index_q      <= 5'd0;
            entryhi_q    <= 32'd0;
            random_q     <= 5'd31;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            if_paddr_q   <= 32'd0;
            dm_paddr_q   <= 32'd0;
            if_exc_q     <= 3'd0;
            dm_exc_q     <= 3'd0;
            probe_miss_q <= 1'b0;
            probe_idx_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            last_dm_q    <= last_dm_d;
            code_q       <= code_d;
            index_q      <= index_d;
            entryhi_q    <= entryhi_d;
            random_q     <= random_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            if_paddr_q   <= if_paddr_d;
            dm_paddr_q   <= dm_paddr_d;
            if_exc_q     <= if_exc_d;
            dm_exc_q     <= dm_exc_d;
            probe_miss_q <= probe_miss_d;
            probe_idx_q  <= probe_idx_d;
        end
    end

endmodule
